sn_to_bin_decoder: RTL and testbench

Stochastic-to-binary decoder: counts the ones in a unipolar stochastic bitstream over a fixed window of 2^WINDOW_LOG2 valid samples and returns the count as a binary value. It sits downstream of the xorwow-driven binary-to-stochastic encoders and closes the loop for stochastic-computing datapaths. Conversions are started explicitly, and results are returned through a valid/ready handshake.

---
 rtl/sn_to_bin_decoder.sv | 125 ++++++++++++
 tb/tb_sn_to_bin_decoder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sn_to_bin_decoder.sv
// Stochastic-to-binary decoder: counts ones over 2^WINDOW_LOG2 valid samples of a
// unipolar bitstream and returns the count through a valid/ready output.
module sn_to_bin_decoder #(
    parameter int WINDOW_LOG2 = 8,
    parameter int CNT_W       = WINDOW_LOG2 + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clear,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic [CNT_W-1:0] out_count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overrun
);

    // Handshake: a result transfers on a rising edge where out_valid && out_ready;
    // out_valid/out_count stay stable until then and out_valid never drops early.

    localparam int SW = WINDOW_LOG2 + 1;
    localparam logic [SW-1:0] LAST_IDX = SW'((1 << WINDOW_LOG2) - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [SW-1:0]    sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             out_valid_q, out_valid_d;
    logic             overrun_q, overrun_d;
    logic             busy_q, busy_d;

    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        acc_d        = acc_q;
        out_count_d  = out_count_q;
        out_valid_d  = out_valid_q;
        overrun_d    = overrun_q;

        if (clear) begin
            // Abort wins over everything else; overrun is deliberately kept.
            state_d      = IDLE;
            sample_cnt_d = '0;
            acc_d        = '0;
            out_count_d  = '0;
            out_valid_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d      = ACCUM;
                        sample_cnt_d = '0;
                        acc_d        = '0;
                        overrun_d    = 1'b0;
                    end
                end
                ACCUM: begin
                    if (bit_valid) begin
                        sample_cnt_d = sample_cnt_q + SW'(1);
                        acc_d        = acc_q + CNT_W'(bit_in);
                        if (sample_cnt_q == LAST_IDX) begin
                            state_d     = DONE;
                            out_count_d = acc_q + CNT_W'(bit_in);
                            out_valid_d = 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bit_valid) begin
                        overrun_d = 1'b1;
                    end
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = IDLE;
                        if (start) begin
                            state_d      = ACCUM;
                            sample_cnt_d = '0;
                            acc_d        = '0;
                            overrun_d    = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sample_cnt_q <= '0;
            acc_q        <= '0;
            out_count_q  <= '0;
            out_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            acc_q        <= acc_d;
            out_count_q  <= out_count_d;
            out_valid_q  <= out_valid_d;
            overrun_q    <= overrun_d;
            busy_q       <= busy_d;
        end
    end

    assign out_count = out_count_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_sn_to_bin_decoder.sv
// Bench for sn_to_bin_decoder: a 16-sample instance for protocol corners and a
// 256-sample instance fed by an xorwow-derived stream.
module tb_sn_to_bin_decoder;

  logic clk;
  logic rst_n;

  // 16-sample instance
  logic       start, clear, bit_in, bit_valid, out_ready;
  logic [4:0] out_count;
  logic       out_valid, busy, overrun;

  // 256-sample instance
  logic       s8_start, s8_clear, s8_bit_in, s8_bit_valid, s8_out_ready;
  logic [8:0] s8_out_count;
  logic       s8_out_valid, s8_busy, s8_overrun;

  logic [4:0] exp_q[$];
  logic [8:0] exp8_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  sn_to_bin_decoder #(.WINDOW_LOG2(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
    .bit_in(bit_in), .bit_valid(bit_valid), .out_count(out_count),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .overrun(overrun)
  );

  sn_to_bin_decoder #(.WINDOW_LOG2(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(s8_start), .clear(s8_clear),
    .bit_in(s8_bit_in), .bit_valid(s8_bit_valid), .out_count(s8_out_count),
    .out_valid(s8_out_valid), .out_ready(s8_out_ready), .busy(s8_busy),
    .overrun(s8_overrun)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // scoreboards: compare each handshaken result against the queued expectation
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) check_val("unexpected_out4", 32'(out_count), 32'hFFFF_FFFF);
      else check_val("out_count4", 32'(out_count), 32'(exp_q.pop_front()));
    end
    if (rst_n && s8_out_valid && s8_out_ready) begin
      if (exp8_q.size() == 0) check_val("unexpected_out8", 32'(s8_out_count), 32'hFFFF_FFFF);
      else check_val("out_count8", 32'(s8_out_count), 32'(exp8_q.pop_front()));
    end
  end

  // driver tasks (inputs change 1 time unit after the rising edge)
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic b);
    bit_valid = 1'b1;
    bit_in    = b;
    tick();
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // xorwow reference generator
  logic [31:0] xw_x, xw_y, xw_z, xw_w, xw_v, xw_d;

  task automatic xw_seed(input logic [31:0] seed);
    xw_x = seed;
    xw_y = 32'd362436069;
    xw_z = 32'd521288629;
    xw_w = 32'd88675123;
    xw_v = 32'd5783321;
    xw_d = 32'd6615241;
  endtask

  task automatic xw_next(output logic [31:0] r);
    logic [31:0] t;
    t    = xw_x ^ (xw_x >> 2);
    xw_x = xw_y;
    xw_y = xw_z;
    xw_z = xw_w;
    xw_w = xw_v;
    xw_v = (xw_v ^ (xw_v << 4)) ^ (t ^ (t << 1));
    xw_d = xw_d + 32'd362437;
    r    = xw_d + xw_v;
  endtask

  initial begin
    int ones;
    logic b;
    logic [31:0] rnd;

    start = 0; clear = 0; bit_in = 0; bit_valid = 0; out_ready = 0;
    s8_start = 0; s8_clear = 0; s8_bit_in = 0; s8_bit_valid = 0; s8_out_ready = 1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    check_val("rst_out_count", 32'(out_count), 0);
    check_val("rst_out_valid", 32'(out_valid), 0);
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_overrun", 32'(overrun), 0);

    // all ones
    do_start();
    check_val("busy_after_start", 32'(busy), 1);
    for (int i = 0; i < 15; i++) send(1'b1);
    check_val("ones_not_early", 32'(out_valid), 0);
    send(1'b1);
    check_val("ones_valid_lat1", 32'(out_valid), 1);
    check_val("ones_count_held", 32'(out_count), 16);
    check_val("ones_overrun", 32'(overrun), 0);
    exp_q.push_back(5'd16);
    handshake();
    check_val("ones_valid_drop", 32'(out_valid), 0);
    check_val("ones_busy_idle", 32'(busy), 0);
    send(1'b1);
    check_val("idle_no_overrun", 32'(overrun), 0);

    // alternating with a gap, stray start in ACCUM
    do_start();
    for (int i = 0; i < 8; i++) send(1'(~i[0]));
    start = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    for (int i = 8; i < 15; i++) send(1'(~i[0]));
    check_val("alt_not_early", 32'(out_valid), 0);
    send(1'b0);
    check_val("alt_valid_lat1", 32'(out_valid), 1);
    check_val("alt_count_held", 32'(out_count), 8);

    // hold with dropped samples, stray start without ready
    bit_valid = 1'b1; bit_in = 1'b1;
    repeat (4) tick();
    start = 1'b1;
    tick();
    start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    check_val("hold_count", 32'(out_count), 8);
    check_val("hold_valid", 32'(out_valid), 1);
    check_val("hold_overrun", 32'(overrun), 1);
    exp_q.push_back(5'd8);
    out_ready = 1'b1; start = 1'b1;
    tick();
    out_ready = 1'b0; start = 1'b0;
    check_val("b2b_busy", 32'(busy), 1);
    check_val("b2b_valid", 32'(out_valid), 0);
    check_val("b2b_overrun_clr", 32'(overrun), 0);

    // abort after 7 samples (3 ones), then a fresh window with 5 ones
    for (int i = 0; i < 7; i++) send(1'(i < 5 && !i[0]));
    clear = 1'b1; start = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    tick();
    clear = 1'b0; start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    check_val("clr_busy", 32'(busy), 0);
    check_val("clr_out_count", 32'(out_count), 0);
    check_val("clr_out_valid", 32'(out_valid), 0);
    do_start();
    for (int i = 0; i < 16; i++) send(1'(i % 3 == 0 && i < 13));
    check_val("clr_valid", 32'(out_valid), 1);
    exp_q.push_back(5'd5);
    handshake();

    // async reset mid-window after a held result left out_count nonzero
    do_start();
    for (int i = 0; i < 5; i++) send(1'b1);
    #3 rst_n = 1'b0;
    #1;
    check_val("arst_valid", 32'(out_valid), 0);
    check_val("arst_busy", 32'(busy), 0);
    check_val("arst_count", 32'(out_count), 0);
    #2 rst_n = 1'b1;
    tick();
    do_start();
    ones = 0;
    for (int i = 0; i < 16; i++) begin
      b = 1'($urandom_range(0, 1));
      ones += int'(b);
      if (i == 7) tick();
      send(b);
    end
    check_val("post_rst_valid", 32'(out_valid), 1);
    exp_q.push_back(5'(ones));
    handshake();

    // 256-sample window from xorwow, threshold 64/256
    xw_seed(32'hDEADBEEF);
    s8_start = 1'b1;
    tick();
    s8_start = 1'b0;
    ones = 0;
    for (int i = 0; i < 256; i++) begin
      xw_next(rnd);
      b = (rnd[31:24] < 8'd64);
      ones += int'(b);
      if (i == 255) exp8_q.push_back(9'(ones));
      s8_bit_valid = 1'b1;
      s8_bit_in    = b;
      tick();
    end
    s8_bit_valid = 1'b0;
    s8_bit_in    = 1'b0;
    check_val("w8_valid", 32'(s8_out_valid), 1);
    tick();
    check_val("w8_valid_drop", 32'(s8_out_valid), 0);

    repeat (2) tick();
    check_val("q4_drained", 32'(exp_q.size()), 0);
    check_val("q8_drained", 32'(exp8_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
